// File: rtl/setbits_cmp_checker.sv
// Self-checker for the set-bits comparator: drives an operand pair, counts set bits
// serially, forms the expected relation character and compares the 256-bit display.
module setbits_cmp_checker #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [255:0]     disp_in,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             ready,
  output logic             done,
  output logic             pass,
  output logic [7:0]       exp_char,
  output logic [7:0]       err_cnt
);

  // One extra bit so an all-ones operand (count == WIDTH) cannot wrap.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [7:0] CHAR_GT = 8'h3E;
  localparam logic [7:0] CHAR_LT = 8'h3C;
  localparam logic [7:0] CHAR_EQ = 8'h3D;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    DECIDE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt_a;
  logic [CW-1:0]    cnt_b;
  logic [CW-1:0]    idx;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      A_out    <= '0;
      B_out    <= '0;
      sh_a     <= '0;
      sh_b     <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      idx      <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      pass     <= 1'b0;
      exp_char <= 8'h00;
      err_cnt  <= 8'h00;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            A_out <= a_in;
            B_out <= b_in;
            sh_a  <= a_in;
            sh_b  <= b_in;
            cnt_a <= '0;
            cnt_b <= '0;
            idx   <= '0;
            pass  <= 1'b0;
            ready <= 1'b0;
            state <= COUNT;
          end
        end
        COUNT: begin
          cnt_a <= cnt_a + {{(CW-1){1'b0}}, sh_a[0]};
          cnt_b <= cnt_b + {{(CW-1){1'b0}}, sh_b[0]};
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          idx   <= idx + 1'b1;
          if (idx == CW'(WIDTH - 1)) begin
            state <= DECIDE;
          end
        end
        DECIDE: begin
          if (cnt_a > cnt_b) begin
            exp_char <= CHAR_GT;
          end else if (cnt_a < cnt_b) begin
            exp_char <= CHAR_LT;
          end else begin
            exp_char <= CHAR_EQ;
          end
          state <= CHECK;
        end
        CHECK: begin
          // Full-width compare: any stray upper bit in the display is a failure.
          if (disp_in == {248'b0, exp_char}) begin
            pass <= 1'b1;
          end else begin
            pass <= 1'b0;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'h01;
            end
          end
          done  <= 1'b1;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_setbits_cmp_checker.sv
// Directed bench for setbits_cmp_checker with a behavioural comparator on disp_in
// that can be overridden to inject faulty display strings.
module tb_setbits_cmp_checker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   a_in;
  logic [7:0]   b_in;
  logic [255:0] disp_in;
  logic [7:0]   A_out;
  logic [7:0]   B_out;
  logic         ready;
  logic         done;
  logic         pass;
  logic [7:0]   exp_char;
  logic [7:0]   err_cnt;

  logic         force_en;
  logic [255:0] force_val;
  logic [255:0] real_disp;

  int n_vec = 0;
  int n_err = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  setbits_cmp_checker #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .disp_in  (disp_in),
    .A_out    (A_out),
    .B_out    (B_out),
    .ready    (ready),
    .done     (done),
    .pass     (pass),
    .exp_char (exp_char),
    .err_cnt  (err_cnt)
  );

  // Behavioural comparator: relation of the set-bit counts of A_out/B_out.
  always_comb begin
    real_disp = '0;
    if ($countones(A_out) > $countones(B_out))      real_disp[7:0] = 8'h3E;
    else if ($countones(A_out) < $countones(B_out)) real_disp[7:0] = 8'h3C;
    else                                             real_disp[7:0] = 8'h3D;
  end
  assign disp_in = force_en ? force_val : real_disp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a posedge; runs one full check and verifies the result.
  task automatic run_check(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] ech, input logic epass);
    int lat;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    check("A_out", A_out, a);
    check("B_out", B_out, b);
    check("ready_busy", ready, 1'b0);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, 10);
    check("exp_char", exp_char, ech);
    check("pass", pass, epass);
    if (!epass && exp_err < 255) exp_err++;
    check("err_cnt", err_cnt, exp_err);
    check("ready_done", ready, 1'b1);
    @(posedge clk); #1;
    check("done_drop", done, 1'b0);
  endtask

  task automatic check_reset_vals();
    check("rst_A", A_out, 8'h00);
    check("rst_B", B_out, 8'h00);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_exp", exp_char, 8'h00);
    check("rst_err", err_cnt, 8'h00);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    force_en = 1'b0; force_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Correct comparator
    run_check(8'd64,  8'd31,  8'h3C, 1'b1);
    run_check(8'd21,  8'd129, 8'h3E, 1'b1);
    run_check(8'd224, 8'd7,   8'h3D, 1'b1);
    run_check(8'd2,   8'd7,   8'h3C, 1'b1);
    run_check(8'd9,   8'd2,   8'h3E, 1'b1);
    run_check(8'hFF,  8'h00,  8'h3E, 1'b1);
    run_check(8'h00,  8'h00,  8'h3D, 1'b1);
    run_check(8'hFF,  8'hFF,  8'h3D, 1'b1);

    // Faulty display strings
    force_en = 1'b1;
    force_val = {248'b0, 8'h3C};
    run_check(8'd9, 8'd2, 8'h3E, 1'b0);
    force_val = {247'b0, 1'b1, 8'h3E};
    run_check(8'd9, 8'd2, 8'h3E, 1'b0);
    force_en = 1'b0;
    run_check(8'd9, 8'd2, 8'h3E, 1'b1);
    check("pass_keeps_err", err_cnt, 8'd2);

    // Start ignored while busy
    a_in = 8'd3; b_in = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_in = 8'hF0; b_in = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_A_out", A_out, 8'd3);
    check("busy_B_out", B_out, 8'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("busy_dones", dones, 1);
    check("busy_exp", exp_char, 8'h3E);
    check("busy_A_end", A_out, 8'd3);

    // Drive the error counter into saturation
    force_en = 1'b1;
    force_val = {248'b0, 8'h00};
    while (exp_err < 255) run_check(8'd1, 8'd0, 8'h3E, 1'b0);
    run_check(8'd0, 8'd1, 8'h3C, 1'b0);
    check("err_sat", err_cnt, 8'hFF);
    force_en = 1'b0;

    // Asynchronous reset during COUNT
    a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("rst_no_done", dones, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_err = 0;
    run_check(8'd64, 8'd31, 8'h3C, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
